// File: rtl/stream_fifo_pkg.sv
// Shared register map and STATUS bit layout for the MMIO-fronted stream FIFO.
package stream_fifo_pkg;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_THRESH = 2'd3
   } reg_e;

   localparam int STAT_EMPTY     = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_COUNT_LSB = 2;
   localparam int STAT_OVERFLOW  = 31;

   localparam int CTRL_FLUSH   = 0;
   localparam int CTRL_OVF_CLR = 1;

endpackage

// File: rtl/mmio_stream_fifo_sync_fifo.sv
// Synchronous FIFO storage with wrap-around pointers; flush and reset clear pointers, not storage.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mmio_stream_fifo.sv
// MMIO slave that pushes bus writes into a FIFO drained by a valid/ready stream.
// Optional threshold interrupt output enabled by defining STREAM_FIFO_IRQ_EN.
module mmio_stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] rd,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready
`ifdef STREAM_FIFO_IRQ_EN
   ,
   output logic             irq
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   reg_e          reg_sel;
   logic          push_req;
   logic          pop;
   logic          flush;
   logic          ovf_clr;
   logic          ovf_set;
   logic          overflow;
   logic [CW-1:0] thresh;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic [WIDTH-1:0] head;
   logic          unused_bits;

   assign reg_sel  = reg_e'(addr[3:2]);
   assign push_req = we && (reg_sel == REG_DATA);
   assign flush    = we && (reg_sel == REG_CTRL) && wd[CTRL_FLUSH];
   assign ovf_clr  = we && (reg_sel == REG_CTRL) && wd[CTRL_OVF_CLR];
   assign pop      = m_valid && m_ready;
   // Flush discards the push, so it cannot also count as an overflow.
   assign ovf_set  = push_req && full && !pop && !flush;

   assign m_valid  = !empty;
   assign m_data   = head;

   assign unused_bits = ^{addr[WIDTH-1:4], addr[1:0], wd[WIDTH-1:CW]};

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (wd),
      .pop       (pop),
      .flush     (flush),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         thresh   <= CW'(DEPTH / 2);
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (we && (reg_sel == REG_THRESH)) thresh <= wd[CW-1:0];
      end
   end

`ifdef STREAM_FIFO_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else       irq <= (thresh != '0) && (count >= thresh);
   end
`endif

   always_comb begin
      rd = '0;
      case (reg_sel)
         REG_DATA:   rd = empty ? '0 : head;
         REG_STATUS: begin
            rd[STAT_OVERFLOW]               = overflow;
            rd[STAT_COUNT_LSB +: CW]        = count;
            rd[STAT_FULL]                   = full;
            rd[STAT_EMPTY]                  = empty;
         end
         REG_THRESH: rd[CW-1:0] = thresh;
         default:    rd = '0;
      endcase
   end

endmodule

// File: tb/tb_mmio_stream_fifo.sv
// Directed bench for mmio_stream_fifo: register vector table plus multi-cycle sequences.
module tb_mmio_stream_fifo;

   localparam int DEPTH = 16;
   localparam logic [31:0] A_DATA = 32'h0, A_STAT = 32'h4, A_CTRL = 32'h8, A_THR = 32'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        m_valid;
   logic [31:0] m_data;
   logic        m_ready;
`ifdef STREAM_FIFO_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   mmio_stream_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .addr    (addr),
      .wd      (wd),
      .rd      (rd),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
`ifdef STREAM_FIFO_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        r;
      logic [31:0] e_rd;
      logic        e_mv;
      logic [31:0] e_md;
   } vec_t;

   vec_t vt[14];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Drive inputs just after a rising edge, then stop on the falling edge for sampling.
   task automatic set(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
      we = w; addr = a; wd = d; m_ready = r;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      set(1'b1, a, d, 1'b0);
      tick();
   endtask

   task automatic rchk(input string name, input logic [31:0] a, input logic [31:0] exp);
      set(1'b0, a, 32'h0, 1'b0);
      check(name, rd, exp);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]  q[$];
      logic [15:0]  lfsr;
      logic         dp, dr, stall_prev;
      logic [31:0]  md_prev;
      int           sent, recv;

      vt[0]  = '{1'b1, A_DATA, 32'h11,       1'b0, 32'h0,  1'b0, 32'h0};
      vt[1]  = '{1'b1, A_DATA, 32'h22,       1'b0, 32'h11, 1'b1, 32'h11};
      vt[2]  = '{1'b1, A_DATA, 32'h33,       1'b0, 32'h11, 1'b1, 32'h11};
      vt[3]  = '{1'b0, A_STAT, 32'h0,        1'b0, 32'hC,  1'b1, 32'h11};
      vt[4]  = '{1'b1, A_THR,  32'hFFFFFFF3, 1'b0, 32'h8,  1'b1, 32'h11};
      vt[5]  = '{1'b0, A_THR,  32'h0,        1'b0, 32'h13, 1'b1, 32'h11};
      vt[6]  = '{1'b1, A_CTRL, 32'h0,        1'b0, 32'h0,  1'b1, 32'h11};
      vt[7]  = '{1'b0, A_DATA, 32'h0,        1'b1, 32'h11, 1'b1, 32'h11};
      vt[8]  = '{1'b0, 32'h3,  32'h0,        1'b1, 32'h22, 1'b1, 32'h22};
      vt[9]  = '{1'b0, 32'h17, 32'h0,        1'b0, 32'h4,  1'b1, 32'h33};
      vt[10] = '{1'b1, A_CTRL, 32'h1,        1'b0, 32'h0,  1'b1, 32'h33};
      vt[11] = '{1'b0, A_STAT, 32'h0,        1'b0, 32'h1,  1'b0, 32'h0};
      vt[12] = '{1'b0, A_DATA, 32'h0,        1'b1, 32'h0,  1'b0, 32'h0};
      vt[13] = '{1'b1, A_THR,  32'h8,        1'b0, 32'h13, 1'b0, 32'h0};

      reset = 1'b1; we = 1'b0; addr = '0; wd = '0; m_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("reset_status", rd, 32'h1);
      check("reset_m_valid", {31'b0, m_valid}, 32'h0);
      tick();
      rchk("reset_thresh", A_THR, 32'h8);
      rchk("reset_ctrl", A_CTRL, 32'h0);
      rchk("reset_data", A_DATA, 32'h0);

      // Register vector table
      foreach (vt[i]) begin
         set(vt[i].w, vt[i].a, vt[i].d, vt[i].r);
         check($sformatf("vec%0d_rd", i), rd, vt[i].e_rd);
         check($sformatf("vec%0d_mv", i), {31'b0, m_valid}, {31'b0, vt[i].e_mv});
         if (vt[i].e_mv) check($sformatf("vec%0d_md", i), m_data, vt[i].e_md);
         tick();
      end

      // Overflow on full FIFO, dropped word, sticky flag clear
      for (int i = 0; i < DEPTH; i++) wr(A_DATA, 32'hA000 + i);
      rchk("full_status", A_STAT, 32'h42);
      wr(A_DATA, 32'hDEAD);
      rchk("ovf_status", A_STAT, 32'h80000042);
      wr(A_CTRL, 32'h2);
      rchk("ovf_cleared", A_STAT, 32'h42);
      for (int i = 0; i < DEPTH; i++) begin
         set(1'b0, A_STAT, 32'h0, 1'b1);
         check("ovf_drain", m_data, 32'hA000 + i);
         tick();
      end
      rchk("ovf_drained", A_STAT, 32'h1);

      // Push into full FIFO while popping
      for (int i = 0; i < DEPTH; i++) wr(A_DATA, 32'hB000 + i);
      set(1'b1, A_DATA, 32'hBEEF, 1'b1);
      check("pp_head", m_data, 32'hB000);
      tick();
      rchk("pp_status", A_STAT, 32'h42);
      for (int i = 0; i < DEPTH; i++) begin
         set(1'b0, A_STAT, 32'h0, 1'b1);
         check("pp_drain", m_data, (i < DEPTH - 1) ? 32'hB001 + i : 32'hBEEF);
         tick();
      end
      rchk("pp_drained", A_STAT, 32'h1);

      // Flush concurrent with pop
      for (int i = 0; i < 5; i++) wr(A_DATA, 32'hC0 + i);
      rchk("fl_count5", A_STAT, 32'h14);
      set(1'b1, A_CTRL, 32'h1, 1'b1);
      check("fl_head", m_data, 32'hC0);
      tick();
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("fl_status", rd, 32'h1);
      check("fl_m_valid", {31'b0, m_valid}, 32'h0);
      tick();
      wr(A_DATA, 32'h77);
      set(1'b0, A_DATA, 32'h0, 1'b0);
      check("fl_after_data", rd, 32'h77);
      check("fl_after_mdata", m_data, 32'h77);
      tick();
      rchk("fl_after_status", A_STAT, 32'h4);
      wr(A_CTRL, 32'h1);

      // 40-word stream with irregular ready
      lfsr = 16'hACE1; sent = 0; recv = 0; stall_prev = 1'b0; md_prev = '0;
      for (int cyc = 0; cyc < 2000 && recv < 40; cyc++) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         dp = (sent < 40) && (q.size() < DEPTH) && lfsr[0];
         dr = lfsr[3];
         set(dp, dp ? A_DATA : A_STAT, 32'h5000 + sent, dr);
         check("st_valid", {31'b0, m_valid}, {31'b0, (q.size() > 0)});
         if (q.size() > 0) check("st_data", m_data, q[0]);
         if (stall_prev) check("st_hold", m_data, md_prev);
         stall_prev = m_valid && !dr;
         md_prev = m_data;
         tick();
         if (q.size() > 0 && dr) begin
            void'(q.pop_front());
            recv++;
         end
         if (dp) begin
            q.push_back(32'h5000 + sent);
            sent++;
         end
      end
      check("st_received", recv, 32'd40);
      rchk("st_empty", A_STAT, 32'h1);

`ifdef STREAM_FIFO_IRQ_EN
      // Threshold interrupt
      wr(A_THR, 32'h4);
      for (int i = 0; i < 4; i++) wr(A_DATA, 32'hE0 + i);
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("irq_count4", rd, 32'h10);
      check("irq_lag", {31'b0, irq}, 32'h0);
      tick();
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("irq_set", {31'b0, irq}, 32'h1);
      tick();
      set(1'b0, A_STAT, 32'h0, 1'b1);
      tick();
      set(1'b0, A_STAT, 32'h0, 1'b0);
      tick();
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("irq_clear", {31'b0, irq}, 32'h0);
      tick();
      wr(A_CTRL, 32'h1);
`endif

      // Reset overriding a concurrent push
      wr(A_DATA, 32'h1);
      wr(A_DATA, 32'h2);
      wr(A_THR, 32'h3);
      reset = 1'b1;
      set(1'b1, A_DATA, 32'h99, 1'b1);
      tick();
      reset = 1'b0;
      set(1'b0, A_STAT, 32'h0, 1'b0);
      check("rst2_status", rd, 32'h1);
      check("rst2_m_valid", {31'b0, m_valid}, 32'h0);
      tick();
      rchk("rst2_thresh", A_THR, 32'h8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmio_stream_fifo.md
MMIO_STREAM_FIFO -- requirements
Module: mmio_stream_fifo

Interface
REQ-001 Parameter WIDTH, default 32: bus data/address width.
REQ-002 Parameter DEPTH, default 16: FIFO entries; power of two, minimum 2.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  bus write strobe from the interconnect slave port.
REQ-006 addr  input  WIDTH  bus address; only addr[3:2] decoded; addr[1:0] ignored.
REQ-007 wd  input  WIDTH  bus write data.
REQ-008 rd  output  WIDTH  bus read data, combinational from addr and current state.
REQ-009 m_valid  output  1  stream-out data valid.
REQ-010 m_data  output  WIDTH  stream-out data, equal to FIFO head.
REQ-011 m_ready  input  1  stream-out consumer ready.

Function
REQ-012 Register map (addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
REQ-013 Write DATA = push wd; read DATA = head entry without pop (0 when empty).
REQ-014 STATUS read = {overflow at bit 31, zero bits 30..(CW+2), count at bits CW+1..2, full at bit 1, empty at bit 0}; CW = $clog2(DEPTH)+1.
REQ-015 CTRL write: bit0=1 flushes FIFO; bit1=1 clears overflow; read returns 0.
REQ-016 THRESH: read/write, low CW bits stored, upper bits read as 0.
REQ-017 Pop occurs on any cycle with m_valid && m_ready; m_valid = !empty.
REQ-018 Push accepted if count < DEPTH, or if count == DEPTH and a pop occurs in the same cycle.
REQ-019 Push to full FIFO without concurrent pop: data dropped, overflow set sticky.
REQ-020 Simultaneous push and pop: count unchanged, pointers both advance.
REQ-021 Flush concurrent with push or pop: flush wins; count=0, pointers=0, push dropped, overflow unchanged.
REQ-022 Overflow clear and a new overflow in the same cycle: overflow ends set.
REQ-023 Read/write pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-024 Pushed word visible on m_data/DATA one cycle after the write edge (write-to-valid latency 1).
REQ-025 m_data shall hold stable while m_valid && !m_ready.

Reset
REQ-026 On reset: count=0, pointers=0, overflow=0, THRESH=DEPTH/2, m_valid=0, rd reflects reset state.
REQ-027 Reset overrides any concurrent push, pop, flush or register write; storage contents need not reset.

Configuration
REQ-028 Macro STREAM_FIFO_IRQ_EN defined: extra output irq (1 bit), registered, high one cycle after count >= THRESH and THRESH != 0; resets to 0.
REQ-029 Macro undefined: no irq port; THRESH still readable/writable with no effect.

Structure
REQ-030 Package stream_fifo_pkg holds register offset constants (REG_DATA, REG_STATUS, REG_CTRL, REG_THRESH) and STATUS bit positions.
REQ-031 Storage and pointers in sub-module sync_fifo (push/pop/flush in; full/empty/count/head out); mmio_stream_fifo holds decode, overflow, THRESH, irq.

Verification
REQ-032 Reset, then 3 writes DATA=0x11,0x22,0x33, m_ready=0 -> STATUS count=3, m_data=0x11, m_valid=1.
REQ-033 Fill 16 entries, write 17th 0xDEAD -> count=16, full=1, overflow=1, 0xDEAD never appears on m_data; CTRL write 0x2 -> overflow=0.
REQ-034 Full FIFO, push 0xBEEF with m_ready=1 same cycle -> count stays 16, no overflow, 0xBEEF emerges 16th.
REQ-035 Count=5, CTRL write 0x1 with m_ready=1 -> next cycle count=0, empty=1, m_valid=0, no extra pop beyond that cycle's head.
REQ-036 Stream 40 words, m_ready toggling pseudo-randomly -> output order matches input, pointer wrap exercised, m_data stable while stalled.
REQ-037 STREAM_FIFO_IRQ_EN build, THRESH=4, push 4 words -> irq=1 one cycle after 4th push; pop one -> irq=0 next cycle.
